tnn_serial_neuron: RTL and testbench

- Parametrised, time-multiplexed threshold neuron for the TNN accelerator datapath.
- Successor to the fixed 8x2-bit combinational classifier neurons.
- Captures N_IN unsigned activations and sums them LANES per cycle into a positive group and a negative group, selected by a compile-time sign mask.
- Emits a 1-bit decision, pos − neg − THRESH > 0, plus the signed margin, over valid/ready handshakes on both sides.

---
 rtl/tnn_serial_neuron.sv | 156 +++++++++++++++
 tb/tb_tnn_serial_neuron.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_serial_neuron.sv
// Time-multiplexed threshold neuron: folds N_IN unsigned activations, LANES per cycle,
// into a signed margin (pos - neg - THRESH) and emits margin > 0 over valid/ready.
module tnn_serial_neuron #(
    parameter int              N_IN     = 8,
    parameter int              IN_W     = 2,
    parameter int              LANES    = 2,
    parameter logic [N_IN-1:0] POS_MASK = 8'b1000_1001,
    parameter int              THRESH   = 0,
    parameter int              MARGIN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bit,
    output logic [MARGIN_W-1:0]    out_margin
);

    localparam int     K       = (N_IN + LANES - 1) / LANES;
    localparam int     IDX_W   = (K > 1) ? $clog2(K) : 1;
    localparam int     ABS_T   = (THRESH < 0) ? -THRESH : THRESH;
    localparam longint MAX_MAG = longint'(N_IN) * ((longint'(1) << IN_W) - 1) + longint'(ABS_T);
    localparam longint LIMIT   = (longint'(1) << (MARGIN_W - 1)) - 1;

    localparam logic [IDX_W-1:0]           IDX_LAST = IDX_W'(K - 1);
    localparam logic signed [MARGIN_W-1:0] ACC_INIT = MARGIN_W'(-THRESH);

    if (MAX_MAG > LIMIT) begin : g_margin_too_narrow
        $error("tnn_serial_neuron: MARGIN_W cannot hold the worst-case margin");
    end
    if (LANES < 1 || LANES > N_IN) begin : g_bad_lanes
        $error("tnn_serial_neuron: LANES must be in 1..N_IN");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    // Signed contribution of one activation; indices past N_IN pad the ragged last group.
    function automatic logic signed [MARGIN_W-1:0] lane_term(
        input logic [N_IN*IN_W-1:0] vec,
        input int                   i
    );
        logic signed [MARGIN_W-1:0] mag;
        logic signed [MARGIN_W-1:0] term;
        term = '0;
        if (i < N_IN) begin
            mag  = MARGIN_W'(vec[i*IN_W +: IN_W]);
            term = POS_MASK[i] ? mag : -mag;
        end
        return term;
    endfunction

    state_t                     state_q, state_d;
    logic signed [MARGIN_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_IN*IN_W-1:0]       vec_q, vec_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_bit_q, out_bit_d;
    logic signed [MARGIN_W-1:0] out_margin_q, out_margin_d;
    logic                       live_q, live_d;

    logic signed [MARGIN_W-1:0] lane_sum;
    logic signed [MARGIN_W-1:0] acc_next;
    logic                       accept;

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + lane_term(vec_q, int'(idx_q) * LANES + j);
        end
        acc_next = acc_q + lane_sum;
    end

    // live_q keeps in_ready low on the reset edge itself; it rises on the first released edge.
    assign in_ready = live_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        vec_d        = vec_q;
        out_valid_d  = out_valid_q;
        out_bit_d    = out_bit_q;
        out_margin_d = out_margin_q;
        live_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vec_d   = in_data;
                    acc_d   = ACC_INIT;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d      = S_DONE;
                    out_margin_d = acc_next;
                    out_bit_d    = (acc_next > 0);
                    out_valid_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        vec_d   = in_data;
                        acc_d   = ACC_INIT;
                        idx_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            vec_q        <= '0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_margin_q <= '0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            vec_q        <= vec_d;
            out_valid_q  <= out_valid_d;
            out_bit_q    <= out_bit_d;
            out_margin_q <= out_margin_d;
            live_q       <= live_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign out_margin = out_margin_q;

endmodule

// File: tb/tb_tnn_serial_neuron.sv
// Bench for tnn_serial_neuron: three instances (defaults, THRESH=9, LANES=3) checked
// against a plain-arithmetic margin model, with directed and randomized traffic.
module tb_tnn_serial_neuron;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid  [3];
    logic              in_ready  [3];
    logic [15:0]       in_data   [3];
    logic              out_valid [3];
    logic              out_ready [3];
    logic              out_bit   [3];
    logic signed [7:0] out_margin[3];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] MASK = 8'b1000_1001;
    int thr_of[3] = '{0, 9, 0};
    int lat_of[3] = '{4, 4, 3};

    always #5 clk = ~clk;

    tnn_serial_neuron u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bit(out_bit[0]), .out_margin(out_margin[0])
    );

    tnn_serial_neuron #(.THRESH(9)) u_thr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bit(out_bit[1]), .out_margin(out_margin[1])
    );

    tnn_serial_neuron #(.LANES(3)) u_rag (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bit(out_bit[2]), .out_margin(out_margin[2])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum of positive-group inputs minus negative-group inputs minus threshold.
    function automatic int ref_margin(input logic [15:0] d, input int thr);
        int pos = 0;
        int neg = 0;
        for (int i = 0; i < 8; i++) begin
            int x = int'((d >> (2 * i)) & 16'h3);
            if (MASK[i]) pos += x;
            else         neg += x;
        end
        return pos - neg - thr;
    endfunction

    // Presents a vector and returns at the falling edge just after it was accepted.
    task automatic send(input int k, input logic [15:0] d);
        int cnt = 0;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        #1;
        while (!in_ready[k] && cnt < 50) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 50) check("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic expect_result(input int k, input string tag, input int exp_m);
        int cnt = 0;
        while (!out_valid[k] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, cnt, lat_of[k]);
        check({tag, "_margin"}, int'(out_margin[k]), exp_m);
        check({tag, "_bit"}, int'(out_bit[k]), (exp_m > 0) ? 1 : 0);
    endtask

    task automatic retire(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          held_m;
        int          held_b;
        int          seen;

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid[0]), 0);
        check("rst_out_bit", int'(out_bit[0]), 0);
        check("rst_out_margin", int'(out_margin[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready[0]), 1);

        // All inputs at full scale: pos 9, neg 15.
        send(0, 16'hFFFF);
        expect_result(0, "all3", -6);
        retire(0);

        // Only positive inputs active; the THRESH=9 instance sits exactly on the boundary.
        send(0, 16'hC0C3);
        expect_result(0, "pos9", 9);
        retire(0);
        send(1, 16'hC0C3);
        expect_result(1, "thr9_zero", 0);
        retire(1);

        // Backpressure: hold the result, then retire and accept in the same cycle.
        d = 16'h5A3C;
        send(0, d);
        expect_result(0, "bp", ref_margin(d, 0));
        held_m = int'(out_margin[0]);
        held_b = int'(out_bit[0]);
        for (int c = 0; c < 6; c++) begin
            in_data[0] = 16'($urandom);
            @(negedge clk);
            check("bp_valid", int'(out_valid[0]), 1);
            check("bp_margin", int'(out_margin[0]), held_m);
            check("bp_bit", int'(out_bit[0]), held_b);
            check("bp_in_ready", int'(in_ready[0]), 0);
        end
        d = 16'h0F21;
        in_data[0]   = d;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check("b2b_valid_drop", int'(out_valid[0]), 0);
        check("b2b_in_ready", int'(in_ready[0]), 0);
        expect_result(0, "b2b", ref_margin(d, 0));
        retire(0);

        // Reset in the middle of accumulation discards the vector.
        send(0, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", int'(out_valid[0]), 0);
        check("abort_out_margin", int'(out_margin[0]), 0);
        @(negedge clk);
        check("abort_in_ready", int'(in_ready[0]), 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1;
        end
        check("abort_no_emit", seen, 0);
        send(0, 16'hC0C3);
        expect_result(0, "after_abort", 9);
        retire(0);

        // Ragged lanes: LANES=3 leaves one padded lane in the last group.
        send(2, 16'h9000);
        expect_result(2, "ragged", 1);
        retire(2);
        for (int n = 0; n < 4; n++) begin
            d = 16'($urandom);
            send(2, d);
            expect_result(2, "ragged_rand", ref_margin(d, 0));
            retire(2);
        end

        // Random stream with random gaps on both handshakes, scoreboarded in order.
        begin
            int          q[$];
            int          sent = 0;
            int          got  = 0;
            int          cyc  = 0;
            int          e;
            logic [15:0] nxt;
            nxt = 16'($urandom);
            while (got < 20 && cyc < 3000) begin
                @(negedge clk);
                out_ready[0] = ($urandom_range(0, 2) != 0);
                in_valid[0]  = (sent < 20) && ($urandom_range(0, 3) != 0);
                in_data[0]   = nxt;
                #1;
                if (out_valid[0] && out_ready[0]) begin
                    if (q.size() == 0) begin
                        check("stream_spurious", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("stream_margin", int'(out_margin[0]), e);
                        check("stream_bit", int'(out_bit[0]), (e > 0) ? 1 : 0);
                    end
                    got++;
                end
                if (in_valid[0] && in_ready[0]) begin
                    q.push_back(ref_margin(nxt, 0));
                    sent++;
                    nxt = 16'($urandom);
                end
                cyc++;
            end
            @(negedge clk);
            in_valid[0]  = 1'b0;
            out_ready[0] = 1'b0;
            check("stream_count", got, 20);
            check("stream_leftover", q.size(), 0);
            repeat (6) @(negedge clk);
            check("stream_no_dup", int'(out_valid[0]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
